// File: rtl/llsc_mem_ctrl.sv
// MEM-stage data-memory access controller for LW/SW/LL/SC.
// Drives the data-side SRAM-like bus and the LLbit register write port.
module llsc_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op_type,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic              flush,
    input  logic              ll_bit,
    output logic              ll_bit_i,
    output logic              wll,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_o,
    output logic              addr_exc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_FAIL,
        S_DRAIN
    } state_t;

    localparam logic [1:0] OP_LW = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_LL = 2'b10;
    localparam logic [1:0] OP_SC = 2'b11;

    state_t            state;
    state_t            state_n;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:2] ll_addr;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_exc_q;

    logic              accept;
    logic              misaligned;
    logic              done_c;
    logic [DATA_W-1:0] result;
    logic              wll_c;
    logic              ll_next_c;
    logic              link_hit;

    assign accept     = (state == S_IDLE) && op_valid && !flush;
    assign misaligned = (op_addr[1:0] != 2'b00);
    assign link_hit   = (addr_q[ADDR_W-1:2] == ll_addr) && ll_bit;

    always_comb begin
        state_n = state;
        done_c  = 1'b0;
        result  = rdata_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned)
                        state_n = S_IDLE;
                    else if (op_type == OP_SC && !ll_bit)
                        state_n = S_FAIL;
                    else
                        state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                // An accepted request must still see its response
                if (flush)
                    state_n = data_addr_ok ? S_DRAIN : S_IDLE;
                else if (data_addr_ok)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (data_data_ok) begin
                    state_n = S_IDLE;
                    done_c  = !flush;
                    unique case (type_q)
                        OP_SC:   result = {{(DATA_W-1){1'b0}}, 1'b1};
                        OP_SW:   result = '0;
                        default: result = data_rdata;
                    endcase
                end else if (flush) begin
                    state_n = S_DRAIN;
                end
            end
            S_FAIL: begin
                state_n = S_IDLE;
                done_c  = !flush;
                result  = '0;
            end
            S_DRAIN: begin
                if (data_data_ok)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // LLbit register samples every cycle: pass ll_bit through unless writing
    always_comb begin
        wll_c     = 1'b0;
        ll_next_c = ll_bit;
        if (flush) begin
            wll_c     = 1'b1;
            ll_next_c = 1'b0;
        end else if (done_c) begin
            unique case (type_q)
                OP_LL: begin
                    wll_c     = 1'b1;
                    ll_next_c = 1'b1;
                end
                OP_SC: begin
                    if (state == S_DATA) begin
                        wll_c     = 1'b1;
                        ll_next_c = 1'b0;
                    end
                end
                OP_SW: begin
                    if (link_hit) begin
                        wll_c     = 1'b1;
                        ll_next_c = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            type_q     <= OP_LW;
            addr_q     <= '0;
            wdata_q    <= '0;
            ll_addr    <= '0;
            rdata_q    <= '0;
            addr_exc_q <= 1'b0;
        end else begin
            state      <= state_n;
            addr_exc_q <= accept && misaligned;
            if (accept) begin
                type_q  <= op_type;
                addr_q  <= op_addr;
                wdata_q <= op_wdata;
            end
            if (done_c)
                rdata_q <= result;
            if (done_c && type_q == OP_LL)
                ll_addr <= addr_q[ADDR_W-1:2];
        end
    end

    assign done       = rst_n && done_c;
    assign rdata_o    = done ? result : rdata_q;
    assign addr_exc   = addr_exc_q;
    assign data_req   = rst_n && (state == S_ADDR);
    assign data_wr    = data_req && type_q[0];
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign wll        = rst_n && wll_c;
    assign ll_bit_i   = rst_n ? ll_next_c : ll_bit;
    assign stall      = rst_n &&
                        (((state == S_IDLE) && op_valid) ||
                         ((state != S_IDLE) && !done_c));

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Directed bench for llsc_mem_ctrl with a behavioural LLbit register
// and a scripted SRAM-like bus responder.
module tb_llsc_mem_ctrl;

    localparam logic [1:0] LW = 2'b00;
    localparam logic [1:0] SW = 2'b01;
    localparam logic [1:0] LL = 2'b10;
    localparam logic [1:0] SC = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        flush;
    logic        ll_reg;
    logic        ll_bit_i;
    logic        wll;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_o;
    logic        addr_exc;

    int n_cmp = 0;
    int n_err = 0;

    int          r_done_cyc;
    int          r_reqs;
    int          r_stall_cnt;
    logic [31:0] r_rdata;
    logic        r_wll;
    logic        r_llbi;
    logic        r_stall_done;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;

    llsc_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .flush        (flush),
        .ll_bit       (ll_reg),
        .ll_bit_i     (ll_bit_i),
        .wll          (wll),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .stall        (stall),
        .done         (done),
        .rdata_o      (rdata_o),
        .addr_exc     (addr_exc)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!rst_n) ll_reg <= 1'b0;
        else        ll_reg <= ll_bit_i;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one op and run the bus until done (20-cycle budget)
    task automatic do_op(input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input int aw, input int dw,
                         input logic [31:0] rd);
        int ph;
        int awc;
        int dwc;
        ph = 0; awc = 0; dwc = 0;
        r_done_cyc = 0; r_reqs = 0; r_stall_cnt = 0;
        r_rdata = 'x; r_wll = 1'bx; r_llbi = 1'bx; r_stall_done = 1'bx;
        r_wr = 1'b0; r_wdata = '0; r_addr = '0;
        op_valid = 1'b1; op_type = t; op_addr = a; op_wdata = wd;
        for (int c = 1; c <= 20 && r_done_cyc == 0; c++) begin
            bus_idle();
            if (ph == 0 && data_req) begin
                if (awc == aw) begin
                    data_addr_ok = 1'b1;
                    ph = 1;
                end else awc++;
            end else if (ph == 1) begin
                if (dwc == dw) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rd;
                    ph = 2;
                end else dwc++;
            end
            @(negedge clk);
            if (data_req && data_addr_ok) begin
                r_reqs++;
                r_wr    = data_wr;
                r_wdata = data_wdata;
                r_addr  = data_addr;
            end
            if (stall) r_stall_cnt++;
            if (done) begin
                r_done_cyc   = c;
                r_rdata      = rdata_o;
                r_wll        = wll;
                r_llbi       = ll_bit_i;
                r_stall_done = stall;
            end
            next_cycle();
        end
        op_valid = 1'b0;
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_type = LW; op_addr = '0;
        op_wdata = '0; flush = 1'b0;
        bus_idle();
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req", data_req, 0);
        check("rst_done", done, 0);
        check("rst_exc", addr_exc, 0);
        check("rst_wll", wll, 0);
        check("rst_stall", stall, 0);
        check("rst_rdata", rdata_o, 0);
        next_cycle();

        // SC with no link: fails without touching the bus
        do_op(SC, 32'h8000_0010, 32'h1234, 0, 0, 0);
        check("scf_cyc", r_done_cyc, 2);
        check("scf_rdata", r_rdata, 0);
        check("scf_reqs", r_reqs, 0);
        check("scf_stall", r_stall_cnt, 1);
        check("scf_wll", r_wll, 0);

        // LL with two data wait cycles
        do_op(LL, 32'h8000_0010, 0, 0, 2, 32'hDEAD_BEEF);
        check("ll_cyc", r_done_cyc, 5);
        check("ll_rdata", r_rdata, 32'hDEAD_BEEF);
        check("ll_wll", r_wll, 1);
        check("ll_llbi", r_llbi, 1);
        check("ll_addr", 32'(dut.ll_addr), 32'h2000_0004);
        check("ll_bus_addr", r_addr, 32'h8000_0010);
        check("ll_bus_wr", r_wr, 0);
        check("ll_stall_done", r_stall_done, 0);
        @(negedge clk);
        check("ll_hold", rdata_o, 32'hDEAD_BEEF);
        check("ll_done_low", done, 0);
        next_cycle();

        // SC with link set: one write, succeeds, clears link
        do_op(SC, 32'h8000_0010, 32'h1234, 0, 0, 0);
        check("sc_cyc", r_done_cyc, 3);
        check("sc_reqs", r_reqs, 1);
        check("sc_wr", r_wr, 1);
        check("sc_wdata", r_wdata, 32'h1234);
        check("sc_rdata", r_rdata, 1);
        check("sc_wll", r_wll, 1);
        check("sc_llbi", r_llbi, 0);

        // SW to the linked word breaks the link
        do_op(LL, 32'h8000_0010, 0, 0, 0, 32'h55);
        do_op(SW, 32'h8000_0010, 32'hAA, 0, 0, 0);
        check("swh_wll", r_wll, 1);
        check("swh_llbi", r_llbi, 0);
        check("swh_rdata", r_rdata, 0);
        do_op(SC, 32'h8000_0010, 32'h1, 0, 0, 0);
        check("swh_sc_cyc", r_done_cyc, 2);
        check("swh_sc_rdata", r_rdata, 0);
        check("swh_sc_reqs", r_reqs, 0);

        // SW to a neighbouring word keeps the link
        do_op(LL, 32'h8000_0010, 0, 0, 0, 32'h66);
        do_op(SW, 32'h8000_0014, 32'hBB, 0, 0, 0);
        check("swm_wll", r_wll, 0);
        check("swm_llbi", r_llbi, 1);
        do_op(SC, 32'h8000_0010, 32'h2, 0, 0, 0);
        check("swm_sc_cyc", r_done_cyc, 3);
        check("swm_sc_rdata", r_rdata, 1);

        // Flush during DATA: drain, no done, link cleared
        do_op(LL, 32'h8000_0040, 0, 0, 0, 32'h77);
        op_valid = 1'b1; op_type = LW; op_addr = 32'h8000_0020;
        @(negedge clk);
        next_cycle();
        data_addr_ok = 1'b1;
        @(negedge clk);
        check("fl_req", data_req, 1);
        next_cycle();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("fl_wll", wll, 1);
        check("fl_llbi", ll_bit_i, 0);
        check("fl_done", done, 0);
        check("fl_stall", stall, 1);
        next_cycle();
        flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("dr_stall", stall, 1);
        check("dr_req", data_req, 0);
        next_cycle();
        data_data_ok = 1'b1;
        data_rdata   = 32'h99;
        @(negedge clk);
        check("dr_done", done, 0);
        next_cycle();
        bus_idle();
        @(negedge clk);
        check("dr_stall_end", stall, 0);
        check("dr_rdata_hold", rdata_o, 32'h77);
        next_cycle();
        do_op(SC, 32'h8000_0040, 32'h3, 0, 0, 0);
        check("fl_sc_cyc", r_done_cyc, 2);
        check("fl_sc_rdata", r_rdata, 0);

        // Misaligned address
        op_valid = 1'b1; op_type = LW; op_addr = 32'h8000_0002;
        @(negedge clk);
        check("mis_req0", data_req, 0);
        check("mis_exc0", addr_exc, 0);
        next_cycle();
        op_valid = 1'b0;
        @(negedge clk);
        check("mis_exc1", addr_exc, 1);
        check("mis_req1", data_req, 0);
        next_cycle();
        @(negedge clk);
        check("mis_exc2", addr_exc, 0);
        next_cycle();

        // LW with addr_ok wait states
        do_op(LW, 32'h8000_0030, 0, 2, 0, 32'hCAFE_F00D);
        check("lw_cyc", r_done_cyc, 5);
        check("lw_rdata", r_rdata, 32'hCAFE_F00D);
        check("lw_wll", r_wll, 0);

        // Reset in the middle of ADDR
        op_valid = 1'b1; op_type = LW; op_addr = 32'h8000_0030;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rr_req", data_req, 1);
        op_valid = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_req_off", data_req, 0);
        check("rr_stall", stall, 0);
        check("rr_rdata", rdata_o, 0);
        next_cycle();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111;
        @(negedge clk);
        check("rr_late_done", done, 0);
        next_cycle();
        bus_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/llsc_mem_ctrl.md
Name: llsc_mem_ctrl

Overview:
- MEM-stage data-memory access controller for LW/SW/LL/SC.
- Issues requests on the data-side SRAM-like bus (req/addr_ok/data_ok) and holds the pipeline stall while an access is outstanding.
- Directly drives the LLbit register's next-value and write-enable inputs, and consumes that register's current output to decide SC success.
- Keeps the LL word address so that a plain store to the linked word breaks the link.

Parameters:
ADDR_W  32  data bus address width
DATA_W  32  data bus data width

Ports:
clk           in   1       clock
rst_n         in   1       active-low reset, synchronous
op_valid      in   1       memory op presented from EXE/MEM register
op_type       in   2       00 LW, 01 SW, 10 LL, 11 SC
op_addr       in   ADDR_W  effective address
op_wdata      in   DATA_W  store data (SW/SC)
flush         in   1       exception/ERET flush; also clears the link
ll_bit        in   1       current LLbit value (combinational output of the LLbit register)
ll_bit_i      out  1       LLbit next value
wll           out  1       LLbit write enable
data_req      out  1       bus request
data_wr       out  1       1 = write
data_addr     out  ADDR_W  bus address
data_wdata    out  DATA_W  bus write data
data_addr_ok  in   1       request accepted
data_data_ok  in   1       read data valid / write completed
data_rdata    in   DATA_W  bus read data
stall         out  1       hold the upstream pipeline
done          out  1       1-cycle pulse: op complete, rdata_o valid
rdata_o       out  DATA_W  LW/LL data; SC result (1 = success, 0 = fail)
addr_exc      out  1       1-cycle pulse: misaligned address (op_addr[1:0] != 0)

Behaviour:
- Reset (rst_n low at a clk edge) returns to IDLE and clears ll_addr, the op latch and every registered output. Output values in reset: data_req=0, done=0, addr_exc=0, wll=0, stall=0, rdata_o=0.
- Reset has priority over flush and aborts any in-flight access. Bus responses that arrive afterwards are ignored.
- States:
  - IDLE: on op_valid, latch op_type/op_addr/op_wdata, then:
    - misaligned -> pulse addr_exc next cycle, no bus access, stay IDLE;
    - SC with ll_bit=0 -> go to FAIL;
    - otherwise -> go to ADDR.
  - ADDR: data_req=1, driving the latched addr/wdata; data_wr=1 for SW/SC. On data_addr_ok go to DATA; otherwise hold every bus output stable.
  - DATA: on data_data_ok, capture the result (data_rdata for LW/LL, 1 for SC, 0 for SW) into rdata_o, pulse done, go to IDLE.
  - FAIL: rdata_o=0, pulse done, no bus activity, go to IDLE.
  - DRAIN: wait for data_data_ok, discard it, go to IDLE. No done pulse.
- Latency: LW/SW/LL/successful SC take 3 cycles minimum (IDLE -> ADDR -> DATA -> done) with zero bus wait. Failed SC takes 2 cycles.
- stall = (IDLE and op_valid) or (state != IDLE). The cycle in which done pulses is not stalled.
- LLbit contract: the LLbit register samples ll_bit_i every cycle, so ll_bit_i must equal ll_bit whenever wll=0.
- LLbit writes happen in the done cycle. Precedence, highest first:
  - flush: drive wll=1, ll_bit_i=0.
  - LL done: wll=1, ll_bit_i=1; ll_addr <= op_addr[ADDR_W-1:2].
  - SC success done: wll=1, ll_bit_i=0.
  - SW done with op_addr[ADDR_W-1:2] == ll_addr and ll_bit=1: wll=1, ll_bit_i=0.
- The SC decision uses ll_bit sampled in IDLE. A flush arriving later does not convert an issued SC into a fail.
- flush behaviour by state:
  - IDLE/ADDR before addr_ok: abandon to IDLE; data_req drops the next cycle.
  - ADDR with addr_ok in the same cycle, or DATA: go to DRAIN (the accepted request must be drained).
  - FAIL: go to IDLE, no done.
  - flush overrides a simultaneous op_valid.
- Simultaneous data_addr_ok and data_data_ok in ADDR is not permitted by the bus and need not be handled.
- rdata_o holds its value until the next done.

Test Plan:
- LL to 0x8000_0010, addr_ok after 0 cycles, data_ok after 2 cycles, rdata 0xDEADBEEF -> done in cycle 5; rdata_o=0xDEADBEEF; wll=1, ll_bit_i=1 in that cycle; ll_addr=0x2000_0004.
- SC to 0x8000_0010 with ll_bit=1, wdata 0x1234 -> one write request on the bus; done with rdata_o=1; wll=1, ll_bit_i=0.
- SC with ll_bit=0 -> data_req never asserts; done on cycle 2 with rdata_o=0; stall high for exactly 1 cycle.
- LL then SW to 0x8000_0010, then SC -> the SW clears the LLbit (wll=1, ll_bit_i=0); the SC then fails with rdata_o=0. Repeat with the SW to 0x8000_0014: the link survives and the SC returns 1.
- LW accepted (addr_ok), flush during DATA -> state DRAIN; data_ok arrives with no done pulse; wll=1, ll_bit_i=0 in the flush cycle; stall drops after the drain.
- op_addr 0x8000_0002 -> addr_exc pulse; no data_req; rst_n=0 mid-ADDR -> data_req=0 and state IDLE at the next edge.
